// File: rtl/gshare_predictor_pkg.sv
// Shared widths and pipeline payload types for the gshare direction predictor.
package gshare_predictor_pkg;

  localparam int unsigned GLOBAL_HISTORY_LEN  = 4;
  localparam int unsigned PC_IDX_LEN          = 4;
  localparam int unsigned PATTERN_HISTORY_LEN = GLOBAL_HISTORY_LEN + PC_IDX_LEN;
  localparam int unsigned PHT_DEPTH           = 1 << PATTERN_HISTORY_LEN;

  // Weakly not-taken: PHT reset value and idle prediction counter.
  localparam logic [1:0] CTR_RESET = 2'b01;

  typedef struct packed {
    logic                           valid;
    logic [PATTERN_HISTORY_LEN-1:0] pht_idx;
    logic [1:0]                     counter;
  } bp_lookup_t;

  typedef struct packed {
    logic                           valid;
    logic [PATTERN_HISTORY_LEN-1:0] pht_idx;
    logic [1:0]                     prediction_val;
    logic                           br_en;
  } bp_commit_t;

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// Combinational 2-bit saturating increment/decrement used on the PHT write path.
module sat_counter2 (
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] next_c
);

  always_comb begin
    next_c = cur;
    if (inc) begin
      if (cur != 2'b11) next_c = cur + 2'd1;
    end else begin
      if (cur != 2'b00) next_c = cur - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: fetch-side lookup, commit-side training.
// Optional commit statistics counters are enabled with GSHARE_PERF_CNT_EN.
module gshare_predictor
  import gshare_predictor_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           lookup_valid,
  input  logic [31:0]                    lookup_pc,
  input  logic                           lookup_is_br,
  output logic                           pred_valid,
  output logic [PATTERN_HISTORY_LEN-1:0] pred_pht_idx,
  output logic [1:0]                     pred_counter,
  output logic                           pred_taken,
  input  logic                           commit_valid,
  input  logic [PATTERN_HISTORY_LEN-1:0] commit_pht_idx,
  input  logic [1:0]                     commit_prediction_val,
  input  logic                           commit_br_en,
  input  logic                           flush,
  output logic [GLOBAL_HISTORY_LEN-1:0]  spec_ghr
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_branches,
  output logic [31:0]                    perf_mispredicts
`endif
);

  logic [1:0]                    pht [PHT_DEPTH];
  logic [GLOBAL_HISTORY_LEN-1:0] commit_ghr;
  logic [GLOBAL_HISTORY_LEN-1:0] commit_ghr_next_c;
  logic [1:0]                    pht_wr_c;
  logic                          lookup_fire_c;
  bp_commit_t                    cmt_c;
  bp_lookup_t                    lkp_c;
  bp_lookup_t                    pred_q;

  // PC bits outside the index window carry no information for this predictor.
  logic unused_c;
  assign unused_c = ^{lookup_pc[31:PC_IDX_LEN+2], lookup_pc[1:0], cmt_c.prediction_val[0]};

  assign cmt_c         = {commit_valid, commit_pht_idx, commit_prediction_val, commit_br_en};
  assign lookup_fire_c = lookup_valid & lookup_is_br & ~flush;

  always_comb begin
    lkp_c         = '0;
    lkp_c.valid   = lookup_fire_c;
    lkp_c.pht_idx = {spec_ghr, lookup_pc[PC_IDX_LEN+1:2]};
    lkp_c.counter = pht[lkp_c.pht_idx];
  end

  assign commit_ghr_next_c = cmt_c.valid ? {commit_ghr[GLOBAL_HISTORY_LEN-2:0], cmt_c.br_en}
                                         : commit_ghr;

  // Training reads the live counter, not the value the branch was predicted with.
  sat_counter2 u_sat (
    .cur    (pht[cmt_c.pht_idx]),
    .inc    (cmt_c.br_en),
    .next_c (pht_wr_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PHT_DEPTH); i++) pht[i] <= CTR_RESET;
    end else if (cmt_c.valid) begin
      pht[cmt_c.pht_idx] <= pht_wr_c;
    end
  end

  // Flush rewinds speculative history to the committed history, including this cycle's commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_ghr <= '0;
      spec_ghr   <= '0;
    end else begin
      commit_ghr <= commit_ghr_next_c;
      if (flush) begin
        spec_ghr <= commit_ghr_next_c;
      end else if (lookup_fire_c) begin
        spec_ghr <= {spec_ghr[GLOBAL_HISTORY_LEN-2:0], lkp_c.counter[1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_q.valid   <= 1'b0;
      pred_q.pht_idx <= '0;
      pred_q.counter <= CTR_RESET;
    end else if (lookup_fire_c) begin
      pred_q <= lkp_c;
    end else begin
      pred_q.valid <= 1'b0;
    end
  end

  assign pred_valid   = pred_q.valid;
  assign pred_pht_idx = pred_q.pht_idx;
  assign pred_counter = pred_q.counter;
  assign pred_taken   = pred_q.counter[1];

`ifdef GSHARE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (cmt_c.valid) begin
      perf_branches <= perf_branches + 32'd1;
      if (cmt_c.prediction_val[1] != cmt_c.br_en) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  logic unused_pv_c;
  assign unused_pv_c = cmt_c.prediction_val[1];
`endif

endmodule
